syscon_rstseq: RTL and testbench

SYSCON_RSTSEQ -- requirements
Module: syscon_rstseq

---
 rtl/syscon_rstseq.sv | 139 +++++++++++++
 tb/tb_syscon_rstseq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/syscon_rstseq.sv
// syscon_rstseq: synchronizes the release of an active-low system reset,
// holds every downstream domain in reset for a fixed time, then releases the
// domains one at a time in ascending index order. From RUN, a one-cycle
// software request replays the hold/release sequence without re-synchronizing.
module syscon_rstseq #(
  parameter int unsigned SYNC_STAGES = 2,  // >= 2
  parameter int unsigned NUM_DOMAINS = 4,  // 1..8
  parameter int unsigned HOLD_CYCLES = 8,  // >= 1
  parameter int unsigned STAGE_GAP   = 4   // >= 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [2:0]             state
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SWRST   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic                   sync_hi_c;

  // Deassertion synchronizer: shifts in a constant 1 once rst is released.
  // The FSM state flop acts as the capture stage of the chain, so the
  // SYNC->HOLD move happens on the same edge the last stage goes high.
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_hi_c = sync_d[SYNC_STAGES-1];

  // Next-state, counter and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;

    case (state_q)
      ST_SYNC: begin
        rst_out_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
        if (sync_hi_c) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        rst_out_d = '1;
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          // Hold expired: domain 0 comes out on this edge.
          state_d   = ST_RELEASE;
          rst_out_d = {NUM_DOMAINS{1'b1}} << 1;
          idx_d     = IDX_W'(1);
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (idx_q == IDX_W'(NUM_DOMAINS)) begin
          // Last domain already released on the previous edge.
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          // Releasing the lowest still-held domain keeps ascending order.
          rst_out_d = rst_out_q << 1;
          idx_d     = idx_q + IDX_W'(1);
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (sw_rst_req) begin
          state_d   = ST_SWRST;
          rst_out_d = '1;
        end
      end

      ST_SWRST: begin
        state_d   = ST_HOLD;
        rst_out_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
      end

      default: begin
        state_d   = ST_SYNC;
        rst_out_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
      end
    endcase
  end

  // ready is registered alongside state so it tracks RUN exactly.
  assign ready_d = (state_d == ST_RUN);

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      state_q   <= ST_SYNC;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign state   = state_q;

endmodule

// File: tb/tb_syscon_rstseq.sv
// Bench for syscon_rstseq: a default instance and a minimal (1/1/1) instance
// share stimulus; outputs are compared every cycle against a timeline model
// that tracks edges since hold entry, plus literal checkpoints.
module tb_syscon_rstseq;

  localparam int SYNC = 2;
  localparam int N0 = 4, H0 = 8, G0 = 4;
  localparam int N1 = 1, H1 = 1, G1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw  = 1'b0;
  logic [3:0] ro0;
  logic       rdy0;
  logic [2:0] st0;
  logic [0:0] ro1;
  logic       rdy1;
  logic [2:0] st1;

  int checks   = 0;
  int failures = 0;

  syscon_rstseq #(.SYNC_STAGES(SYNC), .NUM_DOMAINS(N0), .HOLD_CYCLES(H0), .STAGE_GAP(G0)) u_dut0 (
    .clk(clk), .rst(rst), .sw_rst_req(sw), .rst_out(ro0), .ready(rdy0), .state(st0)
  );

  syscon_rstseq #(.SYNC_STAGES(SYNC), .NUM_DOMAINS(N1), .HOLD_CYCLES(H1), .STAGE_GAP(G1)) u_dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(sw), .rst_out(ro1), .ready(rdy1), .state(st1)
  );

  always #5 clk = ~clk;

  function automatic int p_n(input int j); return (j == 0) ? N0 : N1; endfunction
  function automatic int p_h(input int j); return (j == 0) ? H0 : H1; endfunction
  function automatic int p_g(input int j); return (j == 0) ? G0 : G1; endfunction
  // Edges after hold entry at which the block is in RUN.
  function automatic int run_k(input int j); return p_h(j) + (p_n(j) - 1) * p_g(j) + 1; endfunction

  // Timeline model: m_n = edges seen with rst high while synchronizing,
  // m_k = edges since hold entry (-1 before entry), m_sw = in the SWRST cycle.
  int m_n [2] = '{0, 0};
  int m_k [2] = '{-1, -1};
  bit m_sw[2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst) begin
        m_n[j]  <= 0;
        m_k[j]  <= -1;
        m_sw[j] <= 1'b0;
      end else if (m_sw[j]) begin
        m_sw[j] <= 1'b0;
        m_k[j]  <= 0;
      end else if (m_k[j] < 0) begin
        m_n[j] <= m_n[j] + 1;
        if (m_n[j] + 1 >= SYNC) m_k[j] <= 0;
      end else if (m_k[j] >= run_k(j) && sw) begin
        m_sw[j] <= 1'b1;
      end else if (m_k[j] < 1000000) begin
        m_k[j] <= m_k[j] + 1;
      end
    end
  end

  function automatic logic [7:0] exp_rst(input int j);
    logic [7:0] mask;
    int c;
    mask = 8'((1 << p_n(j)) - 1);
    if (m_sw[j] || m_k[j] < p_h(j)) return mask;
    c = 1 + (m_k[j] - p_h(j)) / p_g(j);
    if (c > p_n(j)) c = p_n(j);
    return mask & ~8'((1 << c) - 1);
  endfunction

  function automatic logic [2:0] exp_state(input int j);
    if (m_sw[j])            return 3'd4;
    if (m_k[j] < 0)         return 3'd0;
    if (m_k[j] < p_h(j))    return 3'd1;
    if (m_k[j] < run_k(j))  return 3'd2;
    return 3'd3;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("cyc_rst_out0", 8'(ro0), exp_rst(0));
    check("cyc_ready0",   8'(rdy0), {7'd0, exp_state(0) == 3'd3});
    check("cyc_state0",   8'(st0), 8'(exp_state(0)));
    check("cyc_rst_out1", 8'(ro1), exp_rst(1));
    check("cyc_ready1",   8'(rdy1), {7'd0, exp_state(1) == 3'd3});
    check("cyc_state1",   8'(st1), 8'(exp_state(1)));
  endtask

  // Advance one rising edge and compare just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Relative edge 1 is the first edge after rst rose; literal checkpoints.
  task automatic boot_checks(input bit with_sw, input int last);
    for (int rel = 1; rel <= last; rel++) begin
      tick();
      sw = with_sw && (rel == 4 || rel == 11);
      if (rel == 1)  check("boot_r1_state0", 8'(st0), 8'd0);
      if (rel == 2) begin
        check("boot_r2_state0",   8'(st0), 8'd1);
        check("boot_r2_rst_out1", 8'(ro1), 8'd1);
        check("boot_r2_state1",   8'(st1), 8'd1);
      end
      if (rel == 3) begin
        check("boot_r3_rst_out1", 8'(ro1), 8'd0);
        check("boot_r3_ready1",   8'(rdy1), 8'd0);
        check("boot_r3_state1",   8'(st1), 8'd2);
      end
      if (rel == 4) begin
        check("boot_r4_ready1", 8'(rdy1), 8'd1);
        check("boot_r4_state1", 8'(st1), 8'd3);
      end
      if (rel == 9) begin
        check("boot_r9_rst_out0", 8'(ro0), 8'h0F);
        check("boot_r9_state0",   8'(st0), 8'd1);
      end
      if (rel == 10) begin
        check("boot_r10_rst_out0", 8'(ro0), 8'h0E);
        check("boot_r10_state0",   8'(st0), 8'd2);
        check("model_r10_rst_out0", exp_rst(0), 8'h0E);
      end
      if (rel == 14) check("boot_r14_rst_out0", 8'(ro0), 8'h0C);
      if (rel == 18) check("boot_r18_rst_out0", 8'(ro0), 8'h08);
      if (rel == 22) begin
        check("boot_r22_rst_out0", 8'(ro0), 8'h00);
        check("boot_r22_ready0",   8'(rdy0), 8'd0);
        check("boot_r22_state0",   8'(st0), 8'd2);
      end
      if (rel == 23) begin
        check("boot_r23_ready0",  8'(rdy0), 8'd1);
        check("boot_r23_state0",  8'(st0), 8'd3);
        check("model_r23_state0", 8'(exp_state(0)), 8'd3);
      end
    end
    sw = 1'b0;
  endtask

  task automatic pin_reset(input string tag);
    check({tag, "_rst_out0"}, 8'(ro0), 8'h0F);
    check({tag, "_ready0"},   8'(rdy0), 8'd0);
    check({tag, "_state0"},   8'(st0), 8'd0);
    check({tag, "_rst_out1"}, 8'(ro1), 8'h01);
  endtask

  initial begin
    int d;
    // Cold boot: reset held at edge 0, released before edge 1.
    tick();
    pin_reset("reset");
    #1 rst = 1'b1;
    boot_checks(1'b0, 23);
    for (int e = 24; e <= 29; e++) tick();

    // Software reset sampled on edge 30.
    sw = 1'b1;
    for (int e = 30; e <= 52; e++) begin
      tick();
      sw = 1'b0;
      if (e == 30) begin
        check("swrst_e30_state0",   8'(st0), 8'd4);
        check("swrst_e30_rst_out0", 8'(ro0), 8'h0F);
        check("swrst_e30_ready0",   8'(rdy0), 8'd0);
      end
      if (e == 31) check("swrst_e31_state0", 8'(st0), 8'd1);
      if (e == 38) check("swrst_e38_rst_out0", 8'(ro0), 8'h0F);
      if (e == 39) check("swrst_e39_rst_out0", 8'(ro0), 8'h0E);
      if (e == 51) check("swrst_e51_ready0", 8'(rdy0), 8'd0);
      if (e == 52) check("swrst_e52_ready0", 8'(rdy0), 8'd1);
    end

    // Reset from RUN, clock and request activity while held.
    rst = 1'b0;
    #1;
    compare_all();
    pin_reset("async_run");
    for (int i = 0; i < 3; i++) begin
      sw = ~sw;
      tick();
    end
    sw  = 1'b0;
    rst = 1'b1;
    // Requests during HOLD and RELEASE, then abort mid-release.
    boot_checks(1'b1, 15);
    check("abort_pre_rst_out0", 8'(ro0), 8'h0C);
    rst = 1'b0;
    #1;
    compare_all();
    pin_reset("abort");
    tick();
    rst = 1'b1;
    boot_checks(1'b0, 23);

    // 1 ns glitch while in RUN.
    tick();
    rst = 1'b0;
    #1;
    compare_all();
    pin_reset("glitch");
    rst = 1'b1;
    boot_checks(1'b0, 23);

    // Random requests and occasional short or multi-cycle reset pulses.
    for (int i = 0; i < 2500; i++) begin
      tick();
      sw = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1;
        compare_all();
        d = int'($urandom_range(1, 6)) + 10 * int'($urandom_range(0, 2));
        #(d) rst = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
